// File: rtl/ras_pkg.sv
// Shared defaults and the checkpoint record for the return address stack.
package ras_pkg;
  localparam int DEF_DEPTH = 16;
  localparam int DEF_AW    = 32;
  localparam int DEF_NCKPT = 4;

  // Record at default geometry; modules with other geometry pass their own via a type parameter.
  typedef struct packed {
    logic [$clog2(DEF_DEPTH)-1:0]   tos;
    logic [$clog2(DEF_DEPTH+1)-1:0] count;
    logic [DEF_AW-1:0]              top_addr;
  } ckpt_rec_t;
endpackage

// File: rtl/ras_ckpt_if.sv
// Predictor-side bus of the return address stack with checkpoint control.
interface ras_ckpt_if #(
  parameter int AW    = ras_pkg::DEF_AW,
  parameter int NCKPT = ras_pkg::DEF_NCKPT
);
  localparam int CW = $clog2(NCKPT);

  logic          PUSH;
  logic [AW-1:0] PUSH_ADDR;
  logic          POP;
  logic [AW-1:0] TOP_ADDR;
  logic          TOP_VALID;
  logic          OVERFLOW;
  logic          CKPT_SAVE;
  logic [CW-1:0] CKPT_ID;
  logic          CKPT_FULL;
  logic          CKPT_RESTORE;
  logic [CW-1:0] CKPT_RESTORE_ID;
  logic          CKPT_RELEASE;

  modport master (
    output PUSH, PUSH_ADDR, POP, CKPT_SAVE, CKPT_RESTORE, CKPT_RESTORE_ID, CKPT_RELEASE,
    input  TOP_ADDR, TOP_VALID, OVERFLOW, CKPT_ID, CKPT_FULL
  );
  modport slave (
    input  PUSH, PUSH_ADDR, POP, CKPT_SAVE, CKPT_RESTORE, CKPT_RESTORE_ID, CKPT_RELEASE,
    output TOP_ADDR, TOP_VALID, OVERFLOW, CKPT_ID, CKPT_FULL
  );
endinterface

// File: rtl/ras_ckpt_queue.sv
// In-order circular checkpoint queue; release is applied before a same-cycle restore.
module ras_ckpt_queue
  import ras_pkg::*;
#(
  parameter int  NCKPT = DEF_NCKPT,
  parameter type rec_t = ckpt_rec_t
)(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     stall,
  input  logic                     save,
  input  rec_t                     save_rec,
  input  logic                     restore,
  input  logic [$clog2(NCKPT)-1:0] restore_id,
  input  logic                     rel,
  output logic                     rst_vld,
  output rec_t                     rst_rec,
  output logic [$clog2(NCKPT)-1:0] ckpt_id,
  output logic                     full
);
  localparam int CW  = $clog2(NCKPT);
  localparam int COW = $clog2(NCKPT+1);

  rec_t           slots [NCKPT];
  logic [CW-1:0]  ap, rp, rp_r, off;
  logic [COW-1:0] co, co_r;
  logic           rel_ok, sv_ok;

  assign full    = (co == COW'(NCKPT));
  assign ckpt_id = ap;
  assign rel_ok  = rel && (co != '0);
  assign rp_r    = rp + CW'(rel_ok);
  assign co_r    = co - COW'(rel_ok);
  // Distance from the (post-release) oldest slot; allocated iff it is inside the occupancy.
  assign off     = restore_id - rp_r;
  assign rst_vld = !stall && restore && (COW'(off) < co_r);
  assign rst_rec = slots[restore_id];
  assign sv_ok   = save && !full && !rst_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ap <= '0;
      rp <= '0;
      co <= '0;
    end else if (!stall) begin
      rp <= rp_r;
      if (rst_vld) begin
        ap <= restore_id;
        co <= COW'(off);
      end else begin
        ap <= ap + CW'(sv_ok);
        co <= co_r + COW'(sv_ok);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!stall && sv_ok) slots[ap] <= save_rec;
  end
endmodule

// File: rtl/ras_ckpt.sv
// Circular return address stack with branch checkpoints for misprediction repair.
module ras_ckpt
  import ras_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = DEF_AW,
  parameter int NCKPT = DEF_NCKPT
)(
  input  logic CLK,
  input  logic RST_N,
  input  logic BPU__Stall,
  ras_ckpt_if.slave bus
);
  localparam int PW  = $clog2(DEPTH);
  localparam int CNW = $clog2(DEPTH+1);

  typedef struct packed {
    logic [PW-1:0]  tos;
    logic [CNW-1:0] count;
    logic [AW-1:0]  top_addr;
  } rec_t;

  logic [AW-1:0]  stk [DEPTH];
  logic [PW-1:0]  tos, tos_n, wr_idx;
  logic [CNW-1:0] cnt, cnt_n;
  logic [AW-1:0]  wr_data;
  logic           wr, ovf, ovf_n, rst_vld;
  rec_t           save_rec, rst_rec;

  always_comb begin
    tos_n   = tos;
    cnt_n   = cnt;
    wr      = 1'b0;
    wr_idx  = tos;
    wr_data = bus.PUSH_ADDR;
    ovf_n   = 1'b0;
    if (rst_vld) begin
      tos_n   = rst_rec.tos;
      cnt_n   = rst_rec.count;
      wr      = 1'b1;
      wr_idx  = rst_rec.tos;
      wr_data = rst_rec.top_addr;
    end else if (bus.PUSH && bus.POP && cnt != '0) begin
      wr = 1'b1;
    end else if (bus.PUSH) begin
      // Full stack wraps onto the oldest entry; count saturates.
      tos_n  = tos + 1'b1;
      wr     = 1'b1;
      wr_idx = tos + 1'b1;
      ovf_n  = (cnt == CNW'(DEPTH));
      cnt_n  = ovf_n ? cnt : cnt + 1'b1;
    end else if (bus.POP && cnt != '0) begin
      tos_n = tos - 1'b1;
      cnt_n = cnt - 1'b1;
    end
  end

  // Snapshot reflects this cycle's push/pop, so the written value bypasses the array.
  assign save_rec = '{tos: tos_n, count: cnt_n, top_addr: wr ? wr_data : stk[tos_n]};

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      tos <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (!BPU__Stall) begin
      tos <= tos_n;
      cnt <= cnt_n;
      ovf <= ovf_n;
    end
  end

  always_ff @(posedge CLK) begin
    if (!BPU__Stall && wr) stk[wr_idx] <= wr_data;
  end

  assign bus.TOP_ADDR  = stk[tos];
  assign bus.TOP_VALID = (cnt != '0);
  assign bus.OVERFLOW  = ovf;

  ras_ckpt_queue #(.NCKPT(NCKPT), .rec_t(rec_t)) u_q (
    .clk        (CLK),
    .rst_n      (RST_N),
    .stall      (BPU__Stall),
    .save       (bus.CKPT_SAVE),
    .save_rec   (save_rec),
    .restore    (bus.CKPT_RESTORE),
    .restore_id (bus.CKPT_RESTORE_ID),
    .rel        (bus.CKPT_RELEASE),
    .rst_vld    (rst_vld),
    .rst_rec    (rst_rec),
    .ckpt_id    (bus.CKPT_ID),
    .full       (bus.CKPT_FULL)
  );
endmodule
